// File: rtl/delay_timer_fsm.sv
`default_nettype none
// ============================================================================
// Module   : delay_timer_fsm
// Desc     : Start/abort delay timer: counts N busy cycles, then flags done,
//            with optional auto-reload and optional sticky completion flag.
// Revision : 1.0 - initial release
// ============================================================================
module delay_timer_fsm #(
    parameter int unsigned CNT_W       = 8,
    parameter bit          DONE_STICKY = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [CNT_W-1:0] cycles_i,
    input  logic             periodic_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [1:0]       c_idle    = 2'd0;
    localparam logic [1:0]       c_busy    = 2'd1;
    localparam logic [1:0]       c_done    = 2'd2;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_load;
    logic [CNT_W-1:0] w_load_nxt;
    logic             r_per;
    logic             w_per_nxt;

    logic             w_accept;
    logic             w_last;
    logic             w_in_done;

    assign start_ready_o = (r_state == c_idle);
    assign busy_o        = (r_state == c_busy);
    assign w_in_done     = (r_state == c_done);
    assign count_o       = r_cnt;

    assign w_accept = start_ready_o && start_valid_i;
    // Load is never zero while BUSY, so load-1 cannot underflow here.
    assign w_last   = (r_cnt == (r_load - c_cnt_one));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load_nxt  = r_load;
        w_per_nxt   = r_per;
        case (r_state)
            c_idle: begin
                if (w_accept) begin
                    w_load_nxt = cycles_i;
                    w_cnt_nxt  = '0;
                    if (cycles_i != '0) begin
                        w_state_nxt = c_busy;
                        w_per_nxt   = periodic_i;
                    end else begin
                        w_state_nxt = c_done;
                        w_per_nxt   = 1'b0;
                    end
                end
            end
            c_busy: begin
                if (abort_i) begin
                    w_state_nxt = c_idle;
                    w_cnt_nxt   = '0;
                    w_per_nxt   = 1'b0;
                end else if (w_last) begin
                    w_state_nxt = c_done;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            c_done: begin
                if (abort_i) begin
                    w_state_nxt = c_idle;
                    w_cnt_nxt   = '0;
                    w_per_nxt   = 1'b0;
                end else if (r_per) begin
                    w_state_nxt = c_busy;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = c_idle;
                end
            end
            default: begin
                w_state_nxt = c_idle;
                w_cnt_nxt   = '0;
                w_per_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            r_load  <= '0;
            r_per   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_load  <= w_load_nxt;
            r_per   <= w_per_nxt;
        end
    end

    generate
        if (DONE_STICKY) begin : g_done_sticky
            logic r_sticky;

            // Set only by a non-periodic completion that is not being aborted.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_sticky <= 1'b0;
                end else if (abort_i || w_accept) begin
                    r_sticky <= 1'b0;
                end else if (w_in_done) begin
                    r_sticky <= !r_per;
                end else if (!start_ready_o) begin
                    r_sticky <= 1'b0;
                end
            end

            assign done_o = w_in_done | r_sticky;
        end else begin : g_done_pulse
            assign done_o = w_in_done;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_delay_timer_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_timer_fsm
// Desc     : Directed scenarios plus randomized run against a timeline model,
//            on a pulse-done and a sticky-done instance sharing stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_timer_fsm;

    logic       clk;
    logic       rst_n;
    logic       start_valid;
    logic [7:0] cycles;
    logic       periodic;
    logic       abort;

    logic       ready0, busy0, done0;
    logic [7:0] count0;
    logic       ready1, busy1, done1;
    logic [7:0] count1;

    int n_tests = 0;
    int n_fail  = 0;

    delay_timer_fsm #(.CNT_W(8), .DONE_STICKY(1'b0)) u_dut_pulse (
        .clk_i(clk), .rst_ni(rst_n), .start_valid_i(start_valid),
        .start_ready_o(ready0), .cycles_i(cycles), .periodic_i(periodic),
        .abort_i(abort), .busy_o(busy0), .done_o(done0), .count_o(count0)
    );

    delay_timer_fsm #(.CNT_W(8), .DONE_STICKY(1'b1)) u_dut_sticky (
        .clk_i(clk), .rst_ni(rst_n), .start_valid_i(start_valid),
        .start_ready_o(ready1), .cycles_i(cycles), .periodic_i(periodic),
        .abort_i(abort), .busy_o(busy1), .done_o(done1), .count_o(count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sv, input logic [7:0] cy, input logic per, input logic ab);
        start_valid = sv;
        cycles      = cy;
        periodic    = per;
        abort       = ab;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        step();
        n_tests++;
        if ({busy0, done0, ready0, count0} !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_pulse busy=%b done=%b ready=%b count=%0d required 0 0 1 0",
                     busy0, done0, ready0, count0);
        end
        n_tests++;
        if ({busy1, done1, ready1, count1} !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_sticky busy=%b done=%b ready=%b count=%0d required 0 0 1 0",
                     busy1, done1, ready1, count1);
        end
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        drive(1'b1, 8'd5, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            n_tests++;
            if (busy0 !== 1'b1 || count0 !== 8'(k - 1) || done0 !== 1'b0 || ready0 !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_busy k=%0d busy=%b count=%0d done=%b ready=%b required 1 %0d 0 0",
                         k, busy0, count0, done0, ready0, k - 1);
            end
            step();
        end
        n_tests++;
        if (busy0 !== 1'b0 || done0 !== 1'b1 || ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done busy=%b done=%b ready=%b required 0 1 0", busy0, done0, ready0);
        end
        step();
        n_tests++;
        if (ready0 !== 1'b1 || done0 !== 1'b0 || busy0 !== 1'b0 || done1 !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_idle ready=%b done=%b busy=%b sticky_done=%b required 1 0 0 1",
                     ready0, done0, busy0, done1);
        end
    endtask

    task automatic test_zero();
        drive(1'b1, 8'd0, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        n_tests++;
        if (busy0 !== 1'b0 || done0 !== 1'b1 || ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done busy=%b done=%b ready=%b required 0 1 0", busy0, done0, ready0);
        end
        step();
        n_tests++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || ready0 !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_idle busy=%b done=%b ready=%b required 0 0 1", busy0, done0, ready0);
        end
    endtask

    task automatic test_periodic();
        logic e_done;
        drive(1'b1, 8'd3, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            e_done = ((k % 4) == 0);
            n_tests++;
            if (done0 !== e_done || busy0 !== !e_done || done1 !== e_done || ready0 !== 1'b0) begin
                n_fail++;
                $display("FAIL periodic k=%0d done=%b busy=%b sticky_done=%b ready=%b required done=%b busy=%b",
                         k, done0, busy0, done1, ready0, e_done, !e_done);
            end
            if (k == 9) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        for (int k = 10; k <= 14; k++) begin
            n_tests++;
            if (ready0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0 || count0 !== 8'd0) begin
                n_fail++;
                $display("FAIL periodic_abort k=%0d ready=%b busy=%b done=%b sticky_done=%b count=%0d required 1 0 0 0 0",
                         k, ready0, busy0, done0, done1, count0);
            end
            step();
        end
    endtask

    task automatic test_max();
        drive(1'b1, 8'd255, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 255; k++) begin
            n_tests++;
            if (busy0 !== 1'b1 || count0 !== 8'(k - 1) || done0 !== 1'b0) begin
                n_fail++;
                $display("FAIL max_busy k=%0d busy=%b count=%0d done=%b required 1 %0d 0",
                         k, busy0, count0, done0, k - 1);
            end
            step();
        end
        n_tests++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || count0 !== 8'd254) begin
            n_fail++;
            $display("FAIL max_done done=%b busy=%b count=%0d required 1 0 254", done0, busy0, count0);
        end
        step();
        n_tests++;
        if (ready0 !== 1'b1 || done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL max_idle ready=%b done=%b required 1 0", ready0, done0);
        end
    endtask

    task automatic test_sticky();
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        step();
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        n_tests++;
        if (done1 !== 1'b0 || ready1 !== 1'b1) begin
            n_fail++;
            $display("FAIL sticky_idle_abort done=%b ready=%b required 0 1", done1, ready1);
        end
        drive(1'b1, 8'd2, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'd7, 1'b0, 1'b0);
        n_tests++;
        if (busy1 !== 1'b1 || count1 !== 8'd0 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL sticky_busy1 busy=%b count=%0d done=%b required 1 0 0", busy1, count1, done1);
        end
        step();
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        n_tests++;
        if (busy1 !== 1'b1 || count1 !== 8'd1 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL sticky_busy2 busy=%b count=%0d done=%b required 1 1 0", busy1, count1, done1);
        end
        step();
        n_tests++;
        if (done1 !== 1'b1 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL sticky_rise done=%b busy=%b required 1 0", done1, busy1);
        end
        step();
        for (int k = 4; k <= 8; k++) begin
            n_tests++;
            if (done1 !== 1'b1 || ready1 !== 1'b1 || busy1 !== 1'b0 || done0 !== 1'b0) begin
                n_fail++;
                $display("FAIL sticky_hold k=%0d done=%b ready=%b busy=%b pulse_done=%b required 1 1 0 0",
                         k, done1, ready1, busy1, done0);
            end
            if (k == 8) drive(1'b1, 8'd1, 1'b0, 1'b1);
            step();
        end
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        n_tests++;
        if (busy1 !== 1'b1 || done1 !== 1'b0 || ready1 !== 1'b0) begin
            n_fail++;
            $display("FAIL sticky_restart busy=%b done=%b ready=%b required 1 0 0", busy1, done1, ready1);
        end
        step();
        step();
        n_tests++;
        if (done1 !== 1'b1 || ready1 !== 1'b1 || done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL sticky_again done=%b ready=%b pulse_done=%b required 1 1 0", done1, ready1, done0);
        end
    endtask

    task automatic test_abort_done();
        drive(1'b1, 8'd1, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        step();
        n_tests++;
        if (done1 !== 1'b1 || done0 !== 1'b1 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_done_cycle done=%b pulse_done=%b busy=%b required 1 1 0", done1, done0, busy1);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (done1 !== 1'b0 || ready1 !== 1'b1 || count1 !== 8'd0) begin
                n_fail++;
                $display("FAIL abort_done_after k=%0d done=%b ready=%b count=%0d required 0 1 0",
                         k, done1, ready1, count1);
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'd10, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        step();
        step();
        n_tests++;
        if (busy0 !== 1'b1 || count0 !== 8'd2) begin
            n_fail++;
            $display("FAIL areset_pre busy=%b count=%0d required 1 2", busy0, count0);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy0, count0, ready0, done0, busy1, count1, ready1, done1} !==
            {1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL areset_now busy=%b count=%0d ready=%b done=%b sticky_done=%b required 0 0 1 0 0",
                     busy0, count0, ready0, done0, done1);
        end
        step();
        #3 rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step();
            n_tests++;
            if (done0 !== 1'b0 || done1 !== 1'b0 || busy0 !== 1'b0 || ready0 !== 1'b1) begin
                n_fail++;
                $display("FAIL areset_after k=%0d done=%b sticky_done=%b busy=%b ready=%b required 0 0 0 1",
                         k, done0, done1, busy0, ready0);
            end
        end
    endtask

    // Timeline model: a run accepted at cycle t0 with length n is busy in
    // t0+1..t0+n and done at t0+n+1; periodic runs repeat every n+1 cycles.
    task automatic test_random();
        bit m_run = 0, m_per = 0, m_sticky = 0, m_cnt_known = 1;
        int m_t0 = 0, m_n = 0;
        int k, p, e_cnt;
        bit e_busy, e_done_state, e_done1;
        bit sv, per, ab;
        logic [7:0] cy;
        int r;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (m_run) begin
                k = cyc - m_t0;
                if (m_n == 0) begin
                    e_busy = 0; e_done_state = (k == 1); e_cnt = 0;
                end else if (m_per) begin
                    p = (k - 1) % (m_n + 1);
                    e_busy = (p < m_n); e_done_state = !e_busy;
                    e_cnt = e_busy ? p : m_n - 1;
                end else begin
                    e_busy = (k <= m_n); e_done_state = (k == m_n + 1);
                    e_cnt = e_busy ? k - 1 : m_n - 1;
                end
            end else begin
                e_busy = 0; e_done_state = 0; e_cnt = 0;
            end
            e_done1 = e_done_state || (!m_run && m_sticky);
            n_tests++;
            if (busy0 !== e_busy || done0 !== e_done_state || ready0 !== !m_run ||
                ((m_run || m_cnt_known) && count0 !== 8'(e_cnt))) begin
                n_fail++;
                $display("FAIL rand_pulse cyc=%0d busy=%b done=%b ready=%b count=%0d required %b %b %b %0d",
                         cyc, busy0, done0, ready0, count0, e_busy, e_done_state, !m_run, e_cnt);
            end
            n_tests++;
            if (busy1 !== e_busy || done1 !== e_done1 || ready1 !== !m_run) begin
                n_fail++;
                $display("FAIL rand_sticky cyc=%0d busy=%b done=%b ready=%b required %b %b %b",
                         cyc, busy1, done1, ready1, e_busy, e_done1, !m_run);
            end
            sv  = ($urandom_range(0, 99) < 40);
            r   = $urandom_range(0, 9);
            cy  = (r == 0) ? 8'd0 : (r < 8) ? 8'($urandom_range(1, 6)) : 8'($urandom_range(7, 40));
            per = ($urandom_range(0, 3) == 0);
            ab  = ($urandom_range(0, 29) == 0);
            drive(sv, cy, per, ab);
            if (m_run) begin
                if (ab) begin
                    m_run = 0; m_sticky = 0; m_cnt_known = 1;
                end else if (e_done_state && !m_per) begin
                    m_run = 0; m_sticky = 1; m_cnt_known = 0;
                end
            end else if (sv) begin
                m_run = 1; m_t0 = cyc; m_n = int'(cy);
                m_per = per && (cy != 8'd0); m_sticky = 0;
            end else if (ab) begin
                m_sticky = 0;
            end
            step();
        end
        drive(1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_periodic();
        test_max();
        test_sticky();
        test_abort_done();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
